// File: rtl/dsm_bitstream_modulator_if.sv
// PCM sample handshake plus bitstream/status outputs of the delta-sigma modulator.
interface dsm_bitstream_modulator_if #(
    parameter int IN_W = 16
);
    logic signed [IN_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   bit_out;
    logic                   frame_strobe;
    logic                   underflow;

    modport master (
        output in_data, in_valid,
        input  in_ready, bit_out, frame_strobe, underflow
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, bit_out, frame_strobe, underflow
    );
endinterface

// File: rtl/dsm_bitstream_modulator.sv
// Second-order 1-bit delta-sigma modulator with ZOH frame interpolation (OSR 2^OSR_LOG2).
// Define DSM_DITHER_EN to add LFSR dither at the quantizer input.
module dsm_bitstream_modulator #(
    parameter int OSR_LOG2 = 6,
    parameter int IN_W     = 16
) (
    input logic                       clk,
    input logic                       rst,
    dsm_bitstream_modulator_if.slave  bus
);
    localparam int I1_W = 20;
    localparam int I2_W = 24;
    localparam int S1_W = I1_W + 2;
    localparam int S2_W = I2_W + 2;

    localparam logic signed [S1_W-1:0] FB1   = S1_W'(2 ** (IN_W - 1));
    localparam logic signed [S2_W-1:0] FB2   = S2_W'(2 ** IN_W);
    localparam logic signed [S1_W-1:0] I1_MAX = S1_W'(2 ** (I1_W - 1) - 1);
    localparam logic signed [S1_W-1:0] I1_MIN = S1_W'(-(2 ** (I1_W - 1)));
    localparam logic signed [S2_W-1:0] I2_MAX = S2_W'(2 ** (I2_W - 1) - 1);
    localparam logic signed [S2_W-1:0] I2_MIN = S2_W'(-(2 ** (I2_W - 1)));

    logic [OSR_LOG2-1:0]    cnt_q, cnt_d;
    logic signed [IN_W-1:0] buf_q, buf_d;
    logic                   full_q, full_d;
    logic signed [IN_W-1:0] x_q, x_d;
    logic signed [I1_W-1:0] i1_q, i1_d;
    logic signed [I2_W-1:0] i2_q, i2_d;
    logic                   bit_q, bit_d;
    logic                   fs_q, fs_d;
    logic                   uf_q, uf_d;

    logic                   q;
    logic                   xfer;
    logic signed [S1_W-1:0] sum1;
    logic signed [S2_W-1:0] sum2;

    function automatic logic signed [I1_W-1:0] sat1(input logic signed [S1_W-1:0] v);
        if (v > I1_MAX)      return I1_MAX[I1_W-1:0];
        else if (v < I1_MIN) return I1_MIN[I1_W-1:0];
        else                 return v[I1_W-1:0];
    endfunction

    function automatic logic signed [I2_W-1:0] sat2(input logic signed [S2_W-1:0] v);
        if (v > I2_MAX)      return I2_MAX[I2_W-1:0];
        else if (v < I2_MIN) return I2_MIN[I2_W-1:0];
        else                 return v[I2_W-1:0];
    endfunction

`ifdef DSM_DITHER_EN
    localparam int QS_W = I2_W + 1;
    logic [15:0]            lfsr_q, lfsr_d;
    logic signed [QS_W-1:0] qsum;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        qsum   = QS_W'(i2_q) + QS_W'($signed(lfsr_q[7:0]));
        q      = ~qsum[QS_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
`else
    always_comb q = ~i2_q[I2_W-1];
`endif

    assign bus.in_ready     = ~full_q & ~rst;
    assign bus.bit_out      = bit_q;
    assign bus.frame_strobe = fs_q;
    assign bus.underflow    = uf_q;
    assign xfer             = bus.in_valid & bus.in_ready;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        buf_d  = buf_q;
        full_d = full_q;
        x_d    = x_q;
        fs_d   = 1'b0;
        uf_d   = 1'b0;
        // A transfer can only happen while empty, so it never collides with the move to x.
        if (&cnt_q) begin
            if (full_q) begin
                x_d    = buf_q;
                full_d = 1'b0;
                fs_d   = 1'b1;
            end else begin
                uf_d   = 1'b1;
            end
        end
        if (xfer) begin
            buf_d  = bus.in_data;
            full_d = 1'b1;
        end
        sum1  = S1_W'(i1_q) + S1_W'(x_q) - (q ? FB1 : -FB1);
        sum2  = S2_W'(i2_q) + S2_W'(i1_q) - (q ? FB2 : -FB2);
        i1_d  = sat1(sum1);
        i2_d  = sat2(sum2);
        bit_d = q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            buf_q  <= '0;
            full_q <= 1'b0;
            x_q    <= '0;
            i1_q   <= '0;
            i2_q   <= '0;
            bit_q  <= 1'b0;
            fs_q   <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            buf_q  <= buf_d;
            full_q <= full_d;
            x_q    <= x_d;
            i1_q   <= i1_d;
            i2_q   <= i2_d;
            bit_q  <= bit_d;
            fs_q   <= fs_d;
            uf_q   <= uf_d;
        end
    end
endmodule
